// File: rtl/regfile_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// regfile_dbg_pkg
// Shared definitions for the register-file dump reader: the FSM state
// encoding and the default register count / checksum word index.
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_dbg_pkg;

  // Walk states; CSUM is only reachable when REGDUMP_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    READ   = 3'd2,
    SEND   = 3'd3,
    CSUM   = 3'd4,
    FINISH = 3'd5
  } state_e;

  localparam int REGDUMP_NUM_REGS = 32;
  // The checksum word is tagged with the first index past the register file.
  localparam int REGDUMP_CSUM_IDX = REGDUMP_NUM_REGS;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader_if
// Valid/ready stream carrying (index, value) pairs from the dump reader to
// the test harness or UART dump path.
//   out_valid : word available (producer -> consumer)
//   out_ready : consumer accepts word (consumer -> producer)
//   out_idx   : register index, one extra bit so the checksum word fits
//   out_data  : register value
// Modports: master = dump reader, slave = consumer.
// ---------------------------------------------------------------------------
interface regfile_dump_reader_if
  import regfile_dbg_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader_csum_acc.sv
// ---------------------------------------------------------------------------
// regdump_csum_acc
// Wrapping (mod 2^DATA_W) accumulator for the dump checksum word.
//   clk_i    : clock
//   rst_ni   : synchronous reset, active low
//   clear_i  : zero the sum (accepted start)
//   add_en_i : add data_i this cycle (register word handshake)
//   data_i   : value being sent
//   sum_o    : running sum
// Only instantiated when REGDUMP_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module regdump_csum_acc
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  // Clear wins over add; clear and add never coincide in the walk anyway.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
// Debug reader for the CPU register file. A start pulse freezes register
// writes, walks every register index through one read port and streams each
// (index, value) pair out over a valid/ready interface.
//   clk_i     : system clock, all state on posedge
//   rst_ni    : synchronous reset, active low (aborts a dump, no done)
//   start_i   : single-cycle dump request, honoured only in IDLE
//   busy_o    : high from the cycle after accepted start until done
//   done_o    : one-cycle pulse after the final word handshakes
//   freeze_o  : register file write inhibit (1 = writes blocked)
//   rd_addr_o : register read address (ReadReg2 while busy)
//   rd_data_i : combinational read data for rd_addr_o
//   out_if    : master side of the (index, value) stream
// Optional feature: define REGDUMP_CHECKSUM_EN to append one extra word with
// out_idx = NUM_REGS carrying the wrapping sum of all sent register values.
// ---------------------------------------------------------------------------
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS = REGDUMP_NUM_REGS,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SKIP_X0  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 freeze_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [DATA_W-1:0]    rd_data_i,
  regfile_dump_reader_if.master out_if
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] idx_q,       idx_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              freeze_q,    freeze_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W:0]   out_idx_q,   out_idx_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic handshake;
  assign handshake = out_valid_q && out_if.out_ready;

`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CSUM_IDX = (ADDR_W+1)'(NUM_REGS);

  logic              csumClear;
  logic              csumAdd;
  logic [DATA_W-1:0] csumSum;

  // The value added is the word just accepted, so the sum covers exactly
  // what the consumer saw.
  regdump_csum_acc #(
    .DATA_W (DATA_W)
  ) u_csum_acc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (csumClear),
    .add_en_i (csumAdd),
    .data_i   (out_data_q),
    .sum_o    (csumSum)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      freeze_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      freeze_q    <= freeze_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    freeze_d    = freeze_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
`ifdef REGDUMP_CHECKSUM_EN
    csumClear   = 1'b0;
    csumAdd     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SETTLE;
          idx_d    = FIRST_IDX;
          busy_d   = 1'b1;
          freeze_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          csumClear = 1'b1;
`endif
        end
      end

      // Lets a register write already in flight land before the first read.
      SETTLE: state_d = READ;

      READ: begin
        out_data_d  = rd_data_i;
        out_idx_d   = {1'b0, idx_q};
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        if (handshake) begin
          out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csumAdd     = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FINISH;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end

`ifdef REGDUMP_CHECKSUM_EN
      // First cycle presents the sum (it already includes the last word),
      // then waits for the consumer like SEND does.
      CSUM: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = CSUM_IDX;
          out_data_d  = csumSum;
        end else if (out_if.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FINISH;
        end
      end
`endif

      FINISH: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        freeze_d = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // idx_q is registered, so the read address is stable from SETTLE onward.
  assign rd_addr_o        = idx_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign freeze_o         = freeze_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
// Bench for regfile_dump_reader: a register file model with a write port
// gated by freeze, a consumer with configurable ready patterns, and a
// reference model that predicts the dumped word stream from a snapshot of
// the register file taken at start. Honours REGDUMP_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;

  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int SKIP_X0   = 1;
  localparam int FIRST_IDX = (SKIP_X0 != 0) ? 1 : 0;
  localparam int MAX_CYC   = 2000;

  typedef struct packed {
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk;
  logic              rstN;
  logic              start;
  logic              busy;
  logic              done;
  logic              freeze;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;

  logic              coreWe;
  logic [ADDR_W-1:0] coreWa;
  logic [DATA_W-1:0] coreWd;
  logic              loadEn;
  logic [DATA_W-1:0] loadVals [NUM_REGS];
  logic [DATA_W-1:0] regs     [NUM_REGS];

  int checks = 0;
  int errors = 0;

  regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) outIf ();

  regfile_dump_reader #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SKIP_X0  (SKIP_X0)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .freeze_o  (freeze),
    .rd_addr_o (rdAddr),
    .rd_data_i (rdData),
    .out_if    (outIf.master)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 reads as zero, core writes are dropped while
  // freeze is high, and a backdoor load preloads all registers at once.
  assign rdData = (rdAddr == '0) ? '0 : regs[rdAddr];

  always @(posedge clk) begin
    if (loadEn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= loadVals[i];
    end else if (coreWe && !freeze && coreWa != '0) begin
      regs[coreWa] <= coreWd;
    end
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Backdoor preload; mode 0: xN = N*0x11, 1: all ones, 2: random.
  task automatic preloadRegs(input int mode);
    for (int i = 0; i < NUM_REGS; i++) begin
      case (mode)
        0:       loadVals[i] = DATA_W'(i * 32'h11);
        1:       loadVals[i] = '1;
        default: loadVals[i] = $urandom();
      endcase
    end
    loadEn = 1'b1;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  // Runs one dump and checks it against a snapshot taken now. readyMode:
  // 0 = always ready, 1 = one cycle on / three off, 2 = random. The *Idx
  // arguments trigger events on the handshake of that word (-1 = never).
  task automatic applyStimulus(input int readyMode, input int extraStartIdx,
                               input int writeIdx, input int resetIdx,
                               input bit finishStart, input int expLatency,
                               input string tag);
    word_t             expQ[$];
    word_t             w;
    logic [DATA_W-1:0] sum = '0;
    int cyc = 0, doneCyc = 0, freezeBad = 0, stableBad = 0, extraWords = 0;
    int activity = 0, resetPhase = 0;
    bit finished = 0, aborted = 0, pendStart = 0, prevHold = 0, rdy;
    logic [ADDR_W:0]   prevIdx = '0;
    logic [DATA_W-1:0] prevData = '0;

    for (int i = FIRST_IDX; i < NUM_REGS; i++) begin
      w.idx  = (ADDR_W+1)'(i);
      w.data = (i == 0) ? '0 : regs[i];
      sum    = sum + w.data;
      expQ.push_back(w);
    end
`ifdef REGDUMP_CHECKSUM_EN
    w.idx  = (ADDR_W+1)'(NUM_REGS);
    w.data = sum;
    expQ.push_back(w);
`endif

    start = 1'b1;
    outIf.out_ready = (readyMode == 0);
    while (!finished && !aborted && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      coreWe = 1'b0;
      if (resetPhase == 2) begin
        checkOutput($sformatf("%s outputs after reset", tag),
                    {busy, done, freeze, outIf.out_valid, outIf.out_idx,
                     outIf.out_data, rdAddr}, '0);
        rstN    = 1'b1;
        aborted = 1;
      end else if (resetPhase == 1) begin
        rstN       = 1'b0;
        resetPhase = 2;
      end else begin
        if (pendStart) begin
          start     = 1'b1;
          pendStart = 0;
        end
        if (done === 1'b1) begin
          finished = 1;
          doneCyc  = cyc;
        end else if (!(busy === 1'b1 && freeze === 1'b1)) begin
          freezeBad++;
        end
        if (prevHold && (outIf.out_valid !== 1'b1 || outIf.out_idx !== prevIdx ||
                         outIf.out_data !== prevData))
          stableBad++;
        case (readyMode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 4 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        outIf.out_ready = rdy;
        if (outIf.out_valid === 1'b1 && rdy) begin
          if (expQ.size() == 0) begin
            extraWords++;
          end else begin
            w = expQ.pop_front();
            checkOutput($sformatf("%s idx of word %0d", tag, w.idx), outIf.out_idx, w.idx);
            checkOutput($sformatf("%s data of word %0d", tag, w.idx), outIf.out_data, w.data);
          end
          if (int'(outIf.out_idx) == extraStartIdx) start = 1'b1;
          if (int'(outIf.out_idx) == writeIdx) begin
            coreWe = 1'b1;
            coreWa = ADDR_W'(5);
            coreWd = 32'hDEADBEEF;
          end
          if (int'(outIf.out_idx) == resetIdx) resetPhase = 1;
          if (finishStart && expQ.size() == 0) pendStart = 1;
        end
        prevHold = (outIf.out_valid === 1'b1) && !rdy;
        prevIdx  = outIf.out_idx;
        prevData = outIf.out_data;
      end
    end

    if (aborted) begin
      checkOutput($sformatf("%s no done after reset", tag), finished, 0);
    end else begin
      checkOutput($sformatf("%s dump completed", tag), finished, 1);
      checkOutput($sformatf("%s words missing", tag), expQ.size(), 0);
      checkOutput($sformatf("%s words extra", tag), extraWords, 0);
      checkOutput($sformatf("%s hold while stalled", tag), stableBad, 0);
      checkOutput($sformatf("%s busy/freeze high", tag), freezeBad, 0);
      if (expLatency >= 0 && finished)
        checkOutput($sformatf("%s start-to-done cycles", tag), doneCyc - 1, expLatency);
    end

    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || freeze !== 1'b0 || outIf.out_valid !== 1'b0)
        activity++;
    end
    checkOutput($sformatf("%s idle afterwards", tag), activity, 0);
  endtask

  // Directed sequence of scenarios, each checked against the snapshot model.
  initial begin
    int expLat;
    expLat = 1 + 2 * (NUM_REGS - FIRST_IDX) + 1;
`ifdef REGDUMP_CHECKSUM_EN
    expLat = expLat + 2;
`endif
    rstN = 1'b0;
    start = 1'b0;
    coreWe = 1'b0;
    coreWa = '0;
    coreWd = '0;
    loadEn = 1'b0;
    outIf.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset freeze", freeze, 0);
    checkOutput("reset out_valid", outIf.out_valid, 0);
    checkOutput("reset out_idx", outIf.out_idx, 0);
    checkOutput("reset out_data", outIf.out_data, 0);
    checkOutput("reset rd_addr", rdAddr, 0);
    rstN = 1'b1;
    preloadRegs(0);

    $display("[TB] pattern preload, ready always high");
    applyStimulus(0, -1, -1, -1, 0, expLat, "ready-high");

    $display("[TB] ready one on three off");
    applyStimulus(1, -1, -1, -1, 0, -1, "ready-1of4");

    $display("[TB] core write to x5 during dump");
    applyStimulus(0, -1, 3, -1, 0, expLat, "frozen-write");
    checkOutput("x5 kept by freeze", regs[5], 32'h55);
    coreWe = 1'b1;
    coreWa = ADDR_W'(5);
    coreWd = 32'hDEADBEEF;
    @(negedge clk);
    coreWe = 1'b0;
    checkOutput("x5 written after done", regs[5], 32'hDEADBEEF);
    preloadRegs(0);

    $display("[TB] start while busy and at FINISH");
    applyStimulus(0, 10, -1, -1, 1, expLat, "restart-ignored");

    $display("[TB] reset in the middle of a dump");
    applyStimulus(0, -1, -1, 20, 0, -1, "mid-reset");
    applyStimulus(0, -1, -1, -1, 0, expLat, "after-reset");

    $display("[TB] random contents, random ready");
    for (int r = 0; r < 3; r++) begin
      preloadRegs(2);
      applyStimulus(2, -1, -1, -1, 0, -1, $sformatf("random-%0d", r));
    end

    $display("[TB] all-ones contents");
    preloadRegs(1);
    applyStimulus(0, -1, -1, -1, 0, expLat, "all-ones");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
